// File: rtl/mem_access_seq_pkg.sv
// Shared definitions for the byte-serial memory access sequencer.
package mem_access_seq_pkg;

  // Sequencer states: wait for a request, run byte beats, report completion.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Number of byte beats per access type.
  localparam int BEATS_WORD = 4;
  localparam int BEATS_BYTE = 1;

  // True when the given beat index is the final beat of the access.
  function automatic logic is_last_beat(input logic [1:0] cnt, input logic byte_op);
    int n;
    n = byte_op ? BEATS_BYTE : BEATS_WORD;
    return (int'(cnt) == (n - 1));
  endfunction

endpackage

// File: rtl/mem_access_seq.sv
// Byte-serial memory access sequencer: turns one CPU load/store (byte or
// big-endian word) into 1 or 4 byte beats on an 8-bit memory port, stalling
// the pipeline until the access completes.
module mem_access_seq
  import mem_access_seq_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              is_byte,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              misaligned,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  state_t            state_reg, state_next;
  logic [1:0]        beat_cnt_reg;
  logic              op_write_reg;
  logic              is_byte_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] asm_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic              req_in;
  logic              last_beat;
  logic [7:0]        beat_byte;
  logic [DATA_W-1:0] word_value;
  logic [DATA_W-1:0] byte_value;

  assign req_in     = mem_read | mem_write;
  assign last_beat  = is_last_beat(beat_cnt_reg, is_byte_reg);
  // Completed load value if the current beat is the last one.
  assign word_value = {asm_reg[DATA_W-9:0], mem_rdata};
  assign byte_value = {{(DATA_W-8){mem_rdata[7]}}, mem_rdata};

  // Select the store byte for the current beat (big-endian for words).
  always_comb begin
    beat_byte = wdata_reg[7:0];
    if (!is_byte_reg) begin
      case (beat_cnt_reg)
        2'd0:    beat_byte = wdata_reg[DATA_W-1:DATA_W-8];
        2'd1:    beat_byte = wdata_reg[DATA_W-9:DATA_W-16];
        2'd2:    beat_byte = wdata_reg[DATA_W-17:DATA_W-24];
        default: beat_byte = wdata_reg[DATA_W-25:DATA_W-32];
      endcase
    end
  end

  // State register, request capture, beat counter and load assembly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      beat_cnt_reg <= 2'd0;
      op_write_reg <= 1'b0;
      is_byte_reg  <= 1'b0;
      base_reg     <= '0;
      wdata_reg    <= '0;
      asm_reg      <= '0;
      rdata_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && req_in) begin
        // A combined read+write request is taken as a write.
        op_write_reg <= mem_write;
        is_byte_reg  <= is_byte;
        base_reg     <= is_byte ? addr : {addr[ADDR_W-1:2], 2'b00};
        wdata_reg    <= wdata;
        beat_cnt_reg <= 2'd0;
        asm_reg      <= '0;
      end else if (state_reg == ST_ACCESS && mem_ack) begin
        if (!op_write_reg) begin
          asm_reg <= word_value;
        end
        if (last_beat) begin
          if (!op_write_reg) begin
            rdata_reg <= is_byte_reg ? byte_value : word_value;
          end
        end else begin
          beat_cnt_reg <= beat_cnt_reg + 2'd1;
        end
      end
    end
  end

  // Next-state logic and all control outputs.
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    done       = 1'b0;
    misaligned = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'd0;
    case (state_reg)
      ST_IDLE: begin
        stall = req_in;
        // Word access to an unaligned address: flag it, then proceed aligned.
        misaligned = req_in && !is_byte && (addr[1:0] != 2'b00) && !rst;
        if (req_in) begin
          state_next = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = op_write_reg;
        mem_addr  = base_reg + {{(ADDR_W-2){1'b0}}, beat_cnt_reg};
        mem_wdata = op_write_reg ? beat_byte : 8'd0;
        if (mem_ack && last_beat) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Stores report zero in their completion cycle; otherwise the last load holds.
  assign rdata = (state_reg == ST_DONE && op_write_reg) ? '0 : rdata_reg;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed self-checking bench for mem_access_seq with a byte memory model.
module tb_mem_access_seq;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              mem_read = 1'b0;
  logic              mem_write = 1'b0;
  logic              is_byte = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic              stall;
  logic [DATA_W-1:0] rdata;
  logic              done;
  logic              misaligned;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack = 1'b1;

  logic [7:0]  mem [0:4095];
  logic [31:0] log_addr [$];
  logic [7:0]  log_data [$];

  int checks = 0;
  int failures = 0;

  mem_access_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .is_byte    (is_byte),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .rdata      (rdata),
    .done       (done),
    .misaligned (misaligned),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  assign mem_rdata = mem[mem_addr[11:0]];

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Issue one request at posedge+1, hold it until done, then release.
  task automatic run_access(input logic rd, input logic wr, input logic byt,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] dly_addr, input int dly,
                            output int stall_cyc, output int mis_cyc,
                            output logic [31:0] rd_val);
    int  left;
    bit  seen;
    left = dly;
    seen = 1'b0;
    stall_cyc = 0;
    mis_cyc = 0;
    rd_val = '0;
    mem_read = rd;
    mem_write = wr;
    is_byte = byt;
    addr = a;
    wdata = wd;
    mem_ack = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (stall) stall_cyc++;
      if (misaligned) mis_cyc++;
      if (done) begin
        seen = 1'b1;
        rd_val = rdata;
        check_val("no_req_in_done", {31'd0, mem_req}, 32'd0);
        check_val("no_stall_in_done", {31'd0, stall}, 32'd0);
        break;
      end
      if (mem_req && mem_addr == dly_addr && left > 0) begin
        mem_ack = 1'b0;
        left--;
      end else begin
        mem_ack = 1'b1;
      end
      if (mem_req && mem_ack) begin
        log_addr.push_back(mem_addr);
        log_data.push_back(mem_we ? mem_wdata : mem_rdata);
        if (mem_we) mem[mem_addr[11:0]] = mem_wdata;
      end
    end
    check_val("done_seen", {31'd0, seen}, 32'd1);
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_ack = 1'b1;
  endtask

  initial begin
    int          sc;
    int          mc;
    int          base;
    bit          hit;
    logic [31:0] rv;
    logic [31:0] exp_bytes [4];

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h12;
    mem[12'h101] = 8'h34;
    mem[12'h102] = 8'h56;
    mem[12'h103] = 8'h78;
    mem[12'h203] = 8'h80;

    // Asynchronous reset: outputs clear before any clock edge.
    #1 rst = 1'b1;
    #1;
    check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_rdata", rdata, 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // LW 0x100, ack always high.
    base = log_addr.size();
    run_access(1, 0, 0, 32'h100, 32'h0, 32'hFFFF_FFFF, 0, sc, mc, rv);
    check_val("lw_stall_cycles", sc, 5);
    check_val("lw_rdata", rv, 32'h1234_5678);
    check_val("lw_misaligned", mc, 0);
    check_val("lw_beats", log_addr.size() - base, 4);
    for (int k = 0; k < 4; k++)
      check_val($sformatf("lw_addr%0d", k), log_addr[base+k], 32'h100 + k);

    // LB 0x203, sign extension and single beat.
    base = log_addr.size();
    run_access(1, 0, 1, 32'h203, 32'h0, 32'hFFFF_FFFF, 0, sc, mc, rv);
    check_val("lb_stall_cycles", sc, 2);
    check_val("lb_rdata", rv, 32'hFFFF_FF80);
    check_val("lb_beats", log_addr.size() - base, 1);
    check_val("lb_addr", log_addr[base], 32'h203);
    check_val("lb_rdata_held", rdata, 32'hFFFF_FF80);

    // SW 0x40 with beat 1 (0x41) acked two cycles late.
    base = log_addr.size();
    run_access(0, 1, 0, 32'h40, 32'hDEAD_BEEF, 32'h41, 2, sc, mc, rv);
    check_val("sw_stall_cycles", sc, 7);
    check_val("sw_rdata_zero", rv, 32'd0);
    check_val("sw_beats", log_addr.size() - base, 4);
    exp_bytes[0] = 32'hDE; exp_bytes[1] = 32'hAD; exp_bytes[2] = 32'hBE; exp_bytes[3] = 32'hEF;
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("sw_addr%0d", k), log_addr[base+k], 32'h40 + k);
      check_val($sformatf("sw_byte%0d", k), {24'd0, log_data[base+k]}, exp_bytes[k]);
    end
    check_val("sw_keeps_load_rdata", rdata, 32'hFFFF_FF80);

    // Misaligned LW 0x102: pulse once, access aligned to 0x100.
    base = log_addr.size();
    run_access(1, 0, 0, 32'h102, 32'h0, 32'hFFFF_FFFF, 0, sc, mc, rv);
    check_val("mis_pulse_cycles", mc, 1);
    check_val("mis_rdata", rv, 32'h1234_5678);
    check_val("mis_first_addr", log_addr[base], 32'h100);
    check_val("mis_last_addr", log_addr[base+3], 32'h103);

    // Read+write together is a write; then back-to-back load of the same word.
    base = log_addr.size();
    run_access(1, 1, 0, 32'h80, 32'hCAFE_F00D, 32'hFFFF_FFFF, 0, sc, mc, rv);
    check_val("rw_as_write_stall", sc, 5);
    run_access(1, 0, 0, 32'h80, 32'h0, 32'hFFFF_FFFF, 0, sc, mc, rv);
    check_val("b2b_lw_stall", sc, 5);
    check_val("b2b_lw_rdata", rv, 32'hCAFE_F00D);
    check_val("b2b_total_beats", log_addr.size() - base, 8);

    // Reset during beat 2 of a load.
    mem_read = 1'b1;
    mem_write = 1'b0;
    is_byte = 1'b0;
    addr = 32'h100;
    mem_ack = 1'b1;
    hit = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h102) begin
        hit = 1'b1;
        break;
      end
    end
    check_val("rst_reached_beat2", {31'd0, hit}, 32'd1);
    rst = 1'b1;
    mem_read = 1'b0;
    #1;
    check_val("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check_val("midrst_stall", {31'd0, stall}, 32'd0);
    check_val("midrst_rdata", rdata, 32'd0);
    check_val("midrst_mem_addr", mem_addr, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Sequencer restarts cleanly from IDLE after the abort.
    run_access(1, 0, 1, 32'h203, 32'h0, 32'hFFFF_FFFF, 0, sc, mc, rv);
    check_val("post_rst_lb_stall", sc, 2);
    check_val("post_rst_lb_rdata", rv, 32'hFFFF_FF80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
